// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the mem_copy_dma block-copy engine.
package mem_copy_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        FIN
    } dma_state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Source/destination pointer and byte-count tracker for mem_copy_dma.
// Optional macro MEM_COPY_OVERLAP_EN adds a descending-copy mode chosen at
// load time so overlapping forward copies behave like memmove.
module mem_copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int AW = mem_copy_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic          last
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] remaining_q, remaining_d;

`ifdef MEM_COPY_OVERLAP_EN
    logic          desc_q, desc_d;
    logic [AW-1:0] diff;
    logic          overlap;

    // Destination lands inside the unread tail of the source: walk backwards.
    assign diff    = dst - src;
    assign overlap = (diff != '0) && (diff < len);
`endif

    // Next-state for pointers and count: latch on load, advance on step.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
`ifdef MEM_COPY_OVERLAP_EN
        desc_d      = desc_q;
`endif
        if (load) begin
            remaining_d = len;
`ifdef MEM_COPY_OVERLAP_EN
            desc_d = overlap;
            if (overlap) begin
                rd_ptr_d = src + len - ONE;
                wr_ptr_d = dst + len - ONE;
            end else begin
                rd_ptr_d = src;
                wr_ptr_d = dst;
            end
`else
            rd_ptr_d = src;
            wr_ptr_d = dst;
`endif
        end else if (step) begin
            remaining_d = remaining_q - ONE;
`ifdef MEM_COPY_OVERLAP_EN
            if (desc_q) begin
                rd_ptr_d = rd_ptr_q - ONE;
                wr_ptr_d = wr_ptr_q - ONE;
            end else begin
                rd_ptr_d = rd_ptr_q + ONE;
                wr_ptr_d = wr_ptr_q + ONE;
            end
`else
            rd_ptr_d = rd_ptr_q + ONE;
            wr_ptr_d = wr_ptr_q + ONE;
`endif
        end
    end

    // Pointer/count registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
`ifdef MEM_COPY_OVERLAP_EN
            desc_q      <= 1'b0;
`endif
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
`ifdef MEM_COPY_OVERLAP_EN
            desc_q      <= desc_d;
`endif
        end
    end

    assign rd_ptr = rd_ptr_q;
    assign wr_ptr = wr_ptr_q;
    assign last   = (remaining_q == ONE);

endmodule

// File: rtl/mem_copy_dma.sv
// Block-copy engine and memory-port arbiter in front of the data memory.
// Idle: CPU port passes straight through. Copying: one read/write cycle pair
// per byte, busy stalls the CPU, done pulses once at the end.
// Optional macro MEM_COPY_OVERLAP_EN enables memmove-style descending copies.
module mem_copy_dma
    import mem_copy_pkg::*;
#(
    parameter int AW = mem_copy_pkg::AW,
    parameter int DW = mem_copy_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr_en,
    input  logic [DW-1:0] cpu_dat,
    input  logic [DW-1:0] mem_rd_dat,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wr_dat,
    output logic          busy,
    output logic          done
);

    dma_state_t    state_q, state_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          load, step, last;
    logic [AW-1:0] rd_ptr, wr_ptr;

    mem_copy_addr_gen #(.AW(AW)) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .src    (src_addr),
        .dst    (dst_addr),
        .len    (len),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .last   (last)
    );

    // Next-state and memory-port mux; DMA-side outputs use registered state only.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        load       = 1'b0;
        step       = 1'b0;
        mem_addr   = cpu_addr;
        mem_wr_en  = cpu_wr_en;
        mem_wr_dat = cpu_dat;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load    = 1'b1;
                        state_d = READ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            READ: begin
                mem_addr   = rd_ptr;
                mem_wr_en  = 1'b0;
                mem_wr_dat = buf_q;
                buf_d      = mem_rd_dat;
                state_d    = WRITE;
            end
            WRITE: begin
                mem_addr   = wr_ptr;
                mem_wr_en  = 1'b1;
                mem_wr_dat = buf_q;
                step       = 1'b1;
                state_d    = last ? FIN : READ;
            end
            FIN: begin
                mem_addr   = wr_ptr;
                mem_wr_en  = 1'b0;
                mem_wr_dat = buf_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and byte buffer; reset aborts any copy in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed self-checking bench for mem_copy_dma with a 256x8 memory model.
module tb_mem_copy_dma;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr, dst_addr, len;
    logic [7:0] cpu_addr;
    logic       cpu_wr_en;
    logic [7:0] cpu_dat;
    logic [7:0] mem_rd_dat;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_dat;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         total = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    mem_copy_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .cpu_addr   (cpu_addr),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_dat    (cpu_dat),
        .mem_rd_dat (mem_rd_dat),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_dat (mem_wr_dat),
        .busy       (busy),
        .done       (done)
    );

    assign mem_rd_dat = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;
        if (mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Kick off a copy at the next posedge (edge 0) and drop start afterwards.
    task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < maxc && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] busy_v, done_v;
        int          wr0, dn0;
        logic [31:0] exp4;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        cpu_addr = 8'hF0; cpu_wr_en = 1'b1; cpu_dat = 8'h00;

        // Reset state: IDLE pass-through, no busy/done
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wren_pass", {31'd0, mem_wr_en}, 32'd1);
        @(negedge clk);
        cpu_wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;

        // Basic 4-byte copy with cycle-accurate busy/done
        busy_v = '0; done_v = '0;
        wr0 = wr_cnt;
        kick(8'h10, 8'h40, 8'd4);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            busy_v[c] = busy;
            done_v[c] = done;
        end
        chk("copy4_busy_cycles", {20'd0, busy_v}, 32'h0000_03FE);
        chk("copy4_done_cycle", {20'd0, done_v}, 32'h0000_0200);
        chk("copy4_data", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hAABB_CCDD);
        chk("copy4_wr_count", wr_cnt - wr0, 32'd4);

        // len = 0: done at cycle 1, no writes
        wr0 = wr_cnt;
        kick(8'h10, 8'h40, 8'd0);
        @(negedge clk);
        chk("len0_done_c1", {30'd0, busy, done}, 32'd3);
        @(negedge clk);
        chk("len0_idle_c2", {30'd0, busy, done}, 32'd0);
        chk("len0_no_write", wr_cnt - wr0, 32'd0);
        chk("len0_mem_same", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hAABB_CCDD);

        // Read pointer wraps 0xFF -> 0x00
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
        kick(8'hFE, 8'h20, 8'd4);
        wait_done("wrap_done_seen", 20);
        chk("wrap_data", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h0102_0304);
        chk("wrap_idle_after", {31'd0, busy}, 32'd0);

        // Overlapping forward copy src=0x10 dst=0x11 len=3
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
`ifdef MEM_COPY_OVERLAP_EN
        exp4 = 32'h0101_0203;
`else
        exp4 = 32'h0101_0101;
`endif
        kick(8'h10, 8'h11, 8'd3);
        wait_done("ovl_done_seen", 20);
        chk("ovl_data", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, exp4);

        // Reset during WRITE of byte 2 of a 4-byte copy
        mem[8'h30] = 8'h11; mem[8'h31] = 8'h22; mem[8'h32] = 8'h33; mem[8'h33] = 8'h44;
        dn0 = done_cnt;
        kick(8'h30, 8'h50, 8'd4);
        repeat (4) @(negedge clk);
        chk("abort_in_write", {31'd0, mem_wr_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_wren_follows_cpu", {31'd0, mem_wr_en}, {31'd0, cpu_wr_en});
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_partial", {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]}, 32'h1100_0000);
        chk("abort_no_done", done_cnt - dn0, 32'd0);

        // Idle pass-through CPU write
        cpu_addr = 8'h05; cpu_dat = 8'h5A; cpu_wr_en = 1'b1;
        #1;
        chk("pass_addr", {24'd0, mem_addr}, 32'h05);
        @(negedge clk);
        cpu_wr_en = 1'b0;
        chk("pass_write", {24'd0, mem[8'h05]}, 32'h5A);

        // Start pulsed while busy is ignored
        mem[8'h60] = 8'h07; mem[8'h61] = 8'h08;
        wr0 = wr_cnt; dn0 = done_cnt;
        kick(8'h60, 8'h70, 8'd2);
        @(negedge clk);
        src_addr = 8'h60; dst_addr = 8'h78; len = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_start_one_done", done_cnt - dn0, 32'd1);
        chk("busy_start_writes", wr_cnt - wr0, 32'd2);
        chk("busy_start_data", {16'd0, mem[8'h70], mem[8'h71]}, 32'h0000_0708);
        chk("busy_start_no_second", {16'd0, mem[8'h78], mem[8'h79]}, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
